adc_readout_ctrl: RTL and testbench

ADC_READOUT_CTRL -- requirements
Module: adc_readout_ctrl

---
 rtl/adc_pkg.sv | 25 ++
 rtl/adc_capture_sr.sv | 41 ++++
 rtl/adc_readout_ctrl.sv | 145 ++++++++++++++
 tb/tb_adc_readout_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC readout controller: default geometry,
// FSM state encoding and the cycle-counter width helper.
package adc_pkg;

  localparam int ADC_NBITS_DEFAULT       = 10;
  localparam int ADC_CONV_CYCLES_DEFAULT = 4;

  // Binary-encoded FSM state; constants kept as plain localparams so the
  // encoding stays visible in waveforms and legacy tooling.
  typedef logic [1:0] adc_state_t;

  localparam adc_state_t ST_IDLE  = 2'd0;
  localparam adc_state_t ST_CONV  = 2'd1;
  localparam adc_state_t ST_SHIFT = 2'd2;
  localparam adc_state_t ST_DONE  = 2'd3;

  // Width of the single counter shared by the CONV and SHIFT phases:
  // wide enough to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int conv_cycles, input int nbits);
    int longest;
    longest = (conv_cycles > nbits) ? conv_cycles : nbits;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/adc_capture_sr.sv
// Serial-to-parallel capture register. Shifts left while shift_en is high,
// so the first bit received ends up in the MSB after NBITS shifts.
module adc_capture_sr
  import adc_pkg::*;
#(
  parameter int NBITS = ADC_NBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             adc_sdata,
  output logic [NBITS-1:0] pdata
);

  generate
    if (NBITS > 1) begin : g_multi
      // Shift the new serial bit into the LSB while capture is enabled.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pdata <= {NBITS{1'b0}};
        end else if (shift_en) begin
          pdata <= {pdata[NBITS-2:0], adc_sdata};
        end else begin
          pdata <= pdata;
        end
      end
    end else begin : g_single
      // Single-bit result: capture straight into the only bit.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pdata <= {NBITS{1'b0}};
        end else if (shift_en) begin
          pdata <= adc_sdata;
        end else begin
          pdata <= pdata;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/adc_readout_ctrl.sv
// ADC readout controller: sequences convst strobe, serial bit capture and
// result hand-off with valid/ready and a sticky overrun flag.
module adc_readout_ctrl
  import adc_pkg::*;
#(
  parameter int NBITS       = ADC_NBITS_DEFAULT,
  parameter int CONV_CYCLES = ADC_CONV_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             continuous,
  output logic             adc_convst,
  input  logic             adc_sdata,
  output logic             shift_en,
  output logic [NBITS-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             busy
);

  localparam int CW = cnt_width(CONV_CYCLES, NBITS);

  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_CONV_END = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BITS_END = CW'(NBITS - 1);

  adc_state_t      state;
  adc_state_t      state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [NBITS-1:0] capture;
  logic            load;

  // Next-state and shared phase-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_next = CNT_ZERO;
        if (start || continuous) begin
          state_next = ST_CONV;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (cnt == CNT_CONV_END) begin
          state_next = ST_SHIFT;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_BITS_END) begin
          state_next = ST_DONE;
          cnt_next   = CNT_ZERO;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      ST_DONE: begin
        cnt_next = CNT_ZERO;
        if (continuous) begin
          state_next = ST_CONV;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and state-decoded strobes; strobes are registered from
  // the next state so they line up exactly with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= CNT_ZERO;
      adc_convst <= 1'b0;
      shift_en   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      adc_convst <= (state_next == ST_CONV);
      shift_en   <= (state_next == ST_SHIFT);
      busy       <= (state_next != ST_IDLE);
    end
  end

  // shift_en is high for exactly the SHIFT cycles, so it gates capture.
  adc_capture_sr #(
    .NBITS (NBITS)
  ) u_capture (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .adc_sdata (adc_sdata),
    .pdata     (capture)
  );

  // The result is transferred on the edge that ends the DONE cycle.
  assign load = (state == ST_DONE);

  // Result register and valid/ready handshake; a load takes priority over
  // an accept on the same edge, and only counts as overrun if not accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= {NBITS{1'b0}};
      data_valid <= 1'b0;
    end else if (load) begin
      data_out   <= capture;
      data_valid <= 1'b1;
    end else if (data_valid && data_ready) begin
      data_out   <= data_out;
      data_valid <= 1'b0;
    end else begin
      data_out   <= data_out;
      data_valid <= data_valid;
    end
  end

  // Sticky overrun: set on an unaccepted overwrite, set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (load && data_valid && !data_ready) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_adc_readout_ctrl.sv
// Directed self-checking bench for adc_readout_ctrl with default parameters.
// Cycle c means the interval after posedge c-1; inputs are applied and
// outputs sampled 1 ns after the posedge that opens the cycle.
module tb_adc_readout_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       adc_convst;
  logic       adc_sdata = 1'b0;
  logic       shift_en;
  logic [9:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic       busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  adc_readout_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .continuous  (continuous),
    .adc_convst  (adc_convst),
    .adc_sdata   (adc_sdata),
    .shift_en    (shift_en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vec_cnt++; if (adc_convst !== 1'b0) begin err_cnt++; $display("FAIL reset_convst got=%b exp=0", adc_convst); end
    vec_cnt++; if (shift_en !== 1'b0) begin err_cnt++; $display("FAIL reset_shift_en got=%b exp=0", shift_en); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    vec_cnt++; if (data_out !== 10'h000) begin err_cnt++; $display("FAIL reset_data got=%h exp=000", data_out); end
    tick();
    tick();
    reset = 1'b0;
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  // Default single shot: convst cycles 1-4, shift 5-14, DONE 15, valid 16.
  task automatic test_single_shot();
    logic [9:0] pat;
    logic exp_cv, exp_sh, exp_bz, exp_vl;
    pat = 10'h2CB;
    for (int c = 0; c <= 17; c++) begin
      start     = (c == 0);
      adc_sdata = (c >= 5 && c <= 14) ? pat[14 - c] : 1'b0;
      exp_cv = (c >= 1 && c <= 4);
      exp_sh = (c >= 5 && c <= 14);
      exp_bz = (c >= 1 && c <= 15);
      exp_vl = (c >= 16);
      vec_cnt++; if (adc_convst !== exp_cv) begin err_cnt++; $display("FAIL single_convst c=%0d got=%b exp=%b", c, adc_convst, exp_cv); end
      vec_cnt++; if (shift_en !== exp_sh) begin err_cnt++; $display("FAIL single_shift_en c=%0d got=%b exp=%b", c, shift_en, exp_sh); end
      vec_cnt++; if (busy !== exp_bz) begin err_cnt++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy, exp_bz); end
      vec_cnt++; if (data_valid !== exp_vl) begin err_cnt++; $display("FAIL single_valid c=%0d got=%b exp=%b", c, data_valid, exp_vl); end
      if (c >= 16) begin
        vec_cnt++; if (data_out !== 10'h2CB) begin err_cnt++; $display("FAIL single_data c=%0d got=%h exp=2cb", c, data_out); end
      end
      tick();
    end
    start = 1'b0;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL single_accept_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (data_out !== 10'h2CB) begin err_cnt++; $display("FAIL single_hold_data got=%h exp=2cb", data_out); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL single_overrun got=%b exp=0", overrun); end
  endtask

  // Two continuous conversions with no consumer; continuous dropped during
  // the second one so the block returns to IDLE after it.
  task automatic test_backpressure();
    logic [9:0] p1, p2;
    p1 = 10'h155;
    p2 = 10'h0F3;
    for (int c = 0; c <= 32; c++) begin
      continuous = (c < 17);
      if (c >= 5 && c <= 14) adc_sdata = p1[14 - c];
      else if (c >= 20 && c <= 29) adc_sdata = p2[29 - c];
      else adc_sdata = 1'b0;
      if (c == 16) begin
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid1 got=%b exp=1", data_valid); end
        vec_cnt++; if (data_out !== 10'h155) begin err_cnt++; $display("FAIL bp_data1 got=%h exp=155", data_out); end
        vec_cnt++; if (adc_convst !== 1'b1) begin err_cnt++; $display("FAIL bp_convst2 got=%b exp=1", adc_convst); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL bp_overrun1 got=%b exp=0", overrun); end
      end
      if (c == 31 || c == 32) begin
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL bp_idle_busy c=%0d got=%b exp=0", c, busy); end
        vec_cnt++; if (adc_convst !== 1'b0) begin err_cnt++; $display("FAIL bp_idle_convst c=%0d got=%b exp=0", c, adc_convst); end
        vec_cnt++; if (data_out !== 10'h0F3) begin err_cnt++; $display("FAIL bp_data2 c=%0d got=%h exp=0f3", c, data_out); end
        vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL bp_overrun2 c=%0d got=%b exp=1", c, overrun); end
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_valid2 c=%0d got=%b exp=1", c, data_valid); end
      end
      tick();
    end
    continuous = 1'b0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL bp_clr got=%b exp=0", overrun); end
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_clr_valid got=%b exp=1", data_valid); end
  endtask

  // Overwrite with clr_overrun on the same edge: set wins.
  task automatic test_overrun_priority();
    logic [9:0] pat;
    pat = 10'h0AA;
    for (int c = 0; c <= 16; c++) begin
      start       = (c == 0);
      clr_overrun = (c == 15);
      adc_sdata   = (c >= 5 && c <= 14) ? pat[14 - c] : 1'b0;
      if (c == 16) begin
        vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL prio_overrun got=%b exp=1", overrun); end
        vec_cnt++; if (data_out !== 10'h0AA) begin err_cnt++; $display("FAIL prio_data got=%h exp=0aa", data_out); end
      end
      tick();
    end
    start = 1'b0;
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL prio_clr got=%b exp=0", overrun); end
  endtask

  // data_ready high exactly on the DONE edge while a result is pending.
  task automatic test_accept_and_load();
    logic [9:0] pat;
    pat = 10'h3A5;
    for (int c = 0; c <= 16; c++) begin
      start      = (c == 0);
      data_ready = (c == 15);
      adc_sdata  = (c >= 5 && c <= 14) ? pat[14 - c] : 1'b0;
      if (c == 15) begin
        vec_cnt++; if (data_out !== 10'h0AA) begin err_cnt++; $display("FAIL al_hold got=%h exp=0aa", data_out); end
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL al_valid_pre got=%b exp=1", data_valid); end
      end
      if (c == 16) begin
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL al_valid got=%b exp=1", data_valid); end
        vec_cnt++; if (data_out !== 10'h3A5) begin err_cnt++; $display("FAIL al_data got=%h exp=3a5", data_out); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL al_overrun got=%b exp=0", overrun); end
      end
      tick();
    end
    start = 1'b0;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL al_accept got=%b exp=0", data_valid); end
  endtask

  // A second start pulse in SHIFT must neither restart nor queue.
  task automatic test_start_ignored();
    logic [9:0] pat;
    pat = 10'h1E0;
    for (int c = 0; c <= 22; c++) begin
      start      = (c == 0 || c == 8);
      data_ready = (c == 16);
      adc_sdata  = (c >= 5 && c <= 14) ? pat[14 - c] : 1'b0;
      if (c == 8) begin
        vec_cnt++; if (shift_en !== 1'b1) begin err_cnt++; $display("FAIL ign_shift c=8 got=%b exp=1", shift_en); end
      end
      if (c >= 16) begin
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL ign_busy c=%0d got=%b exp=0", c, busy); end
        vec_cnt++; if (adc_convst !== 1'b0) begin err_cnt++; $display("FAIL ign_convst c=%0d got=%b exp=0", c, adc_convst); end
        vec_cnt++; if (data_valid !== (c == 16)) begin err_cnt++; $display("FAIL ign_valid c=%0d got=%b exp=%b", c, data_valid, (c == 16)); end
        vec_cnt++; if (data_out !== 10'h1E0) begin err_cnt++; $display("FAIL ign_data c=%0d got=%h exp=1e0", c, data_out); end
      end
      tick();
    end
    start = 1'b0;
    data_ready = 1'b0;
  endtask

  // Reset in cycle 8 (mid-SHIFT) clears everything without a clock edge.
  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      start     = (c == 0);
      adc_sdata = 1'b1;
      tick();
    end
    start = 1'b0;
    vec_cnt++; if (shift_en !== 1'b1) begin err_cnt++; $display("FAIL rmid_pre_shift got=%b exp=1", shift_en); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (shift_en !== 1'b0) begin err_cnt++; $display("FAIL rmid_shift got=%b exp=0", shift_en); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    vec_cnt++; if (data_out !== 10'h000) begin err_cnt++; $display("FAIL rmid_data got=%h exp=000", data_out); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got=%b exp=0", data_valid); end
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      vec_cnt++; if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== 10'h000) begin
        err_cnt++; $display("FAIL rmid_after c=%0d valid=%b busy=%b data=%h exp=0/0/000", c, data_valid, busy, data_out);
      end
    end
    adc_sdata = 1'b0;
  endtask

  // Steady continuous: period 15, no IDLE gap; continuous dropped at 50
  // lets the conversion started at 46 finish (DONE at 60, IDLE from 61).
  task automatic test_continuous();
    logic [9:0] pat;
    logic exp_cv, exp_sh, exp_bz;
    int ph;
    pat = 10'h2CB;
    data_ready = 1'b1;
    for (int c = 0; c <= 63; c++) begin
      continuous = (c < 50);
      ph = (c >= 1) ? ((c - 1) % 15) : 0;
      adc_sdata = (c >= 1 && ph >= 4 && ph <= 13) ? pat[13 - ph] : 1'b0;
      exp_bz = (c >= 1 && c <= 60);
      exp_cv = exp_bz && (ph <= 3);
      exp_sh = exp_bz && (ph >= 4) && (ph <= 13);
      vec_cnt++; if (adc_convst !== exp_cv) begin err_cnt++; $display("FAIL cont_convst c=%0d got=%b exp=%b", c, adc_convst, exp_cv); end
      vec_cnt++; if (shift_en !== exp_sh) begin err_cnt++; $display("FAIL cont_shift c=%0d got=%b exp=%b", c, shift_en, exp_sh); end
      vec_cnt++; if (busy !== exp_bz) begin err_cnt++; $display("FAIL cont_busy c=%0d got=%b exp=%b", c, busy, exp_bz); end
      if (c == 61) begin
        vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL cont_valid got=%b exp=1", data_valid); end
        vec_cnt++; if (data_out !== 10'h2CB) begin err_cnt++; $display("FAIL cont_data got=%h exp=2cb", data_out); end
        vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL cont_overrun got=%b exp=0", overrun); end
      end
      tick();
    end
    continuous = 1'b0;
    data_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_backpressure();
    test_overrun_priority();
    test_accept_and_load();
    test_start_ignored();
    test_reset_mid();
    test_continuous();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
